// File: rtl/fetch_queue_if.sv
// Sysbus-side handshake of the fetch queue: line request out, data beats back.
interface fetch_queue_if #(
    parameter int BEAT_BYTES = 8,
    parameter int TAG_W      = 13
);
    logic                    reqcyc;
    logic [63:0]             req;
    logic [TAG_W-1:0]        reqtag;
    logic                    reqack;
    logic                    respcyc;
    logic [8*BEAT_BYTES-1:0] resp;
    logic                    respack;

    modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp);
    modport slave  (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp);
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: pulls whole lines from the Sysbus into a circular
// byte buffer and presents a sliding decode window with variable retirement.
//
// state  | meaning
// IDLE   | no line outstanding; issue one when a full line of space is free
// WAIT   | request held on the bus until reqack
// ACTIVE | receiving beats of the current line into the buffer
// DRAIN  | redirected with a line outstanding; absorb and drop its beats
module fetch_queue #(
    parameter int               BUF_BYTES    = 128,
    parameter int               BEAT_BYTES   = 8,
    parameter int               LINE_BYTES   = 64,
    parameter int               WINDOW_BYTES = 15,
    parameter int               TAG_W        = 13,
    parameter logic [TAG_W-1:0] RD_TAG       = 13'h1100
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [63:0]                       entry,
    input  logic                              redirect_valid,
    input  logic [63:0]                       redirect_rip,
    fetch_queue_if.master                     bus,
    output logic [8*WINDOW_BYTES-1:0]         window,
    output logic                              window_valid,
    output logic [63:0]                       window_rip,
    input  logic [$clog2(WINDOW_BYTES+1)-1:0] consume,
    output logic [$clog2(BUF_BYTES):0]        occupancy
);
    localparam int IW     = $clog2(BUF_BYTES);
    localparam int PW     = IW + 1;
    localparam int LW     = $clog2(LINE_BYTES);
    localparam int OW     = $clog2(BEAT_BYTES);
    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BCW    = $clog2(NBEATS + 1);
    localparam int CW     = $clog2(WINDOW_BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DRAIN} state_t;

    state_t           state;
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic [63:0]      fetch_rip;
    logic [LW-1:0]    skip;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [BCW-1:0]   beat_cnt;     // beats of the outstanding line still to come
    logic             need_ack;     // drain entered before the request was acked
    logic [7:0]       mem [BUF_BYTES];

    logic [BCW-1:0]   bidx;
    logic [BCW-1:0]   skip_beat;
    logic [OW-1:0]    lo;
    logic             wr_en;
    logic             keep_beat;
    logic [OW:0]      n_wr;
    logic             beat_fire;
    logic             last_beat;
    logic [CW-1:0]    consume_eff;

    assign bus.reqcyc   = reqcyc;
    assign bus.req      = req;
    assign bus.reqtag   = reqtag;
    assign bus.respack  = bus.respcyc;

    assign occupancy    = wr_ptr - rd_ptr;
    assign window_valid = occupancy >= PW'(WINDOW_BYTES);
    assign consume_eff  = (window_valid && !redirect_valid) ? consume : '0;
    assign beat_fire    = bus.respcyc && (state == S_ACTIVE || (state == S_DRAIN && !need_ack));
    assign last_beat    = beat_fire && (beat_cnt == BCW'(1));

    // Beat placement: drop beats below the entry offset, trim the one holding it.
    always_comb begin
        bidx      = BCW'(NBEATS) - beat_cnt;
        skip_beat = BCW'(skip[LW-1:OW]);
        lo        = (bidx == skip_beat) ? skip[OW-1:0] : '0;
        wr_en     = (state == S_ACTIVE) && bus.respcyc && !redirect_valid;
        keep_beat = wr_en && (bidx >= skip_beat);
        n_wr      = '0;
        if (keep_beat)
            n_wr = (OW+1)'(BEAT_BYTES) - (OW+1)'(lo);
    end

    // Buffer write; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (!reset && keep_beat)
            for (int j = 0; j < BEAT_BYTES; j++)
                if (OW'(j) >= lo)
                    mem[wr_ptr[IW-1:0] + IW'(j) - IW'(lo)] <= bus.resp[8*j +: 8];
    end

    // Decoder window read with wrap at the end of the buffer.
    always_comb begin
        window = '0;
        for (int i = 0; i < WINDOW_BYTES; i++)
            window[8*i +: 8] = mem[rd_ptr[IW-1:0] + IW'(i)];
    end

    // Fetch FSM, pointers and registered bus outputs; redirect overrides last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            reqcyc     <= 1'b0;
            req        <= '0;
            reqtag     <= '0;
            fetch_rip  <= entry;
            window_rip <= entry;
            skip       <= entry[LW-1:0];
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            need_ack   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(n_wr);
            rd_ptr     <= rd_ptr + PW'(consume_eff);
            window_rip <= window_rip + 64'(consume_eff);
            if (reqcyc && bus.reqack)
                reqcyc <= 1'b0;
            if (beat_fire)
                beat_cnt <= beat_cnt - BCW'(1);
            case (state)
                S_IDLE: begin
                    if (!redirect_valid && occupancy <= PW'(BUF_BYTES - LINE_BYTES)) begin
                        reqcyc   <= 1'b1;
                        req      <= fetch_rip & ~64'(LINE_BYTES - 1);
                        reqtag   <= RD_TAG;
                        beat_cnt <= BCW'(NBEATS);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.reqack)
                        state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (last_beat) begin
                        state     <= S_IDLE;
                        fetch_rip <= (fetch_rip & ~64'(LINE_BYTES - 1)) + 64'(LINE_BYTES);
                        skip      <= '0;
                    end
                end
                S_DRAIN: begin
                    if (need_ack && bus.reqack)
                        need_ack <= 1'b0;
                    if (last_beat)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (redirect_valid) begin
                rd_ptr     <= wr_ptr;
                fetch_rip  <= redirect_rip;
                skip       <= redirect_rip[LW-1:0];
                window_rip <= redirect_rip;
                case (state)
                    S_WAIT: begin
                        state    <= S_DRAIN;
                        need_ack <= !bus.reqack;
                    end
                    S_ACTIVE, S_DRAIN: state <= last_beat ? S_IDLE : S_DRAIN;
                    default:           state <= S_IDLE;
                endcase
            end
        end
    end

    // Retiring bytes the decoder was never shown is a decoder bug.
    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid && consume != '0)
            assert (window_valid);
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: drives the Sysbus side by hand and checks
// the buffer/window against a simple address-derived memory image.
module tb_fetch_queue;
    localparam int               BUF_BYTES    = 128;
    localparam int               BEAT_BYTES   = 8;
    localparam int               LINE_BYTES   = 64;
    localparam int               WINDOW_BYTES = 15;
    localparam int               TAG_W        = 13;
    localparam logic [TAG_W-1:0] RD_TAG       = 13'h1100;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [63:0]               entry = 64'h1000;
    logic                      redirect_valid = 1'b0;
    logic [63:0]               redirect_rip = '0;
    logic [8*WINDOW_BYTES-1:0] window;
    logic                      window_valid;
    logic [63:0]               window_rip;
    logic [3:0]                consume = '0;
    logic [7:0]                occupancy;

    int n_chk = 0;
    int n_bad = 0;

    fetch_queue_if #(.BEAT_BYTES(BEAT_BYTES), .TAG_W(TAG_W)) bus();

    fetch_queue #(
        .BUF_BYTES(BUF_BYTES), .BEAT_BYTES(BEAT_BYTES), .LINE_BYTES(LINE_BYTES),
        .WINDOW_BYTES(WINDOW_BYTES), .TAG_W(TAG_W), .RD_TAG(RD_TAG)
    ) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_rip(redirect_rip),
        .bus(bus),
        .window(window), .window_valid(window_valid), .window_rip(window_rip),
        .consume(consume), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [8*BEAT_BYTES-1:0] beat_data(input logic [63:0] line, input int b);
        logic [8*BEAT_BYTES-1:0] d;
        for (int j = 0; j < BEAT_BYTES; j++)
            d[8*j +: 8] = mem_byte(line + 64'(BEAT_BYTES*b + j));
        return d;
    endfunction

    function automatic logic [8*WINDOW_BYTES-1:0] exp_window(input logic [63:0] rip);
        logic [8*WINDOW_BYTES-1:0] w;
        for (int i = 0; i < WINDOW_BYTES; i++)
            w[8*i +: 8] = mem_byte(rip + 64'(i));
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [63:0] addr);
        int k = 0;
        while (bus.reqcyc !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_reqcyc"}, 128'(bus.reqcyc), 128'(1));
        check_eq({tag, "_req"}, 128'(bus.req), 128'(addr));
        check_eq({tag, "_reqtag"}, 128'(bus.reqtag), 128'(RD_TAG));
    endtask

    task automatic do_ack(input string tag);
        bus.reqack = 1'b1;
        @(negedge clk);
        bus.reqack = 1'b0;
        check_eq({tag, "_reqcyc_drop"}, 128'(bus.reqcyc), 128'(0));
    endtask

    task automatic send_beats(input logic [63:0] line, input int first, input int n, input logic chk_idle);
        for (int b = 0; b < n; b++) begin
            bus.resp    = beat_data(line, first + b);
            bus.respcyc = 1'b1;
            #1;
            if (b == 0)
                check_eq("respack", 128'(bus.respack), 128'(1));
            if (chk_idle)
                check_eq("drain_no_req", 128'(bus.reqcyc), 128'(0));
            @(negedge clk);
        end
        bus.respcyc = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag, input logic [63:0] rip);
        check_eq({tag, "_reqcyc"}, 128'(bus.reqcyc), 128'(0));
        check_eq({tag, "_req"}, 128'(bus.req), 128'(0));
        check_eq({tag, "_reqtag"}, 128'(bus.reqtag), 128'(0));
        check_eq({tag, "_occ"}, 128'(occupancy), 128'(0));
        check_eq({tag, "_wvalid"}, 128'(window_valid), 128'(0));
        check_eq({tag, "_wrip"}, 128'(window_rip), 128'(rip));
    endtask

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        reset = 1'b1;
        entry = e;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset", e);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_occ;
        logic [63:0] exp_rip;
        bus.reqack  = 1'b0;
        bus.respcyc = 1'b0;
        bus.resp    = '0;

        // aligned start, two lines fill the buffer
        do_reset(64'h1000);
        @(negedge clk);
        check_eq("rise_first_edge", 128'(bus.reqcyc), 128'(1));
        wait_req("al0", 64'h1000);
        do_ack("al0");
        send_beats(64'h1000, 0, 8, 1'b0);
        check_eq("al0_occ", 128'(occupancy), 128'(64));
        check_eq("al0_window", 128'(window), 128'(exp_window(64'h1000)));
        wait_req("al1", 64'h1040);
        do_ack("al1");
        send_beats(64'h1040, 0, 8, 1'b0);
        check_eq("al1_occ", 128'(occupancy), 128'(128));
        repeat (5) @(negedge clk);
        check_eq("full_no_req", 128'(bus.reqcyc), 128'(0));

        // streaming consume
        exp_occ = 128;
        exp_rip = 64'h1000;
        for (int i = 0; i < 10; i++) begin
            check_eq("stream_valid", 128'(window_valid), 128'(exp_occ >= 15));
            check_eq("stream_rip", 128'(window_rip), 128'(exp_rip));
            check_eq("stream_occ", 128'(occupancy), 128'(exp_occ));
            if (exp_occ >= 15)
                check_eq("stream_window", 128'(window), 128'(exp_window(exp_rip)));
            consume = (exp_occ >= 15) ? 4'd15 : 4'd0;
            @(negedge clk);
            if (consume != 0) begin
                exp_occ -= 15;
                exp_rip += 15;
            end
        end
        consume = '0;
        wait_req("wrap", 64'h1080);
        do_ack("wrap");
        send_beats(64'h1080, 0, 8, 1'b0);
        check_eq("wrap_occ", 128'(occupancy), 128'(72));
        check_eq("wrap_rip", 128'(window_rip), 128'(64'h1078));
        check_eq("wrap_valid", 128'(window_valid), 128'(1));
        check_eq("wrap_window", 128'(window), 128'(exp_window(64'h1078)));

        // unaligned start
        do_reset(64'h100B);
        wait_req("ua", 64'h1000);
        do_ack("ua");
        send_beats(64'h1000, 0, 8, 1'b0);
        check_eq("ua_occ", 128'(occupancy), 128'(53));
        check_eq("ua_rip", 128'(window_rip), 128'(64'h100B));
        check_eq("ua_byte0", 128'(window[7:0]), 128'(mem_byte(64'h100B)));
        check_eq("ua_window", 128'(window), 128'(exp_window(64'h100B)));
        wait_req("ua_next", 64'h1040);

        // redirect mid-line
        do_reset(64'h1000);
        wait_req("rm", 64'h1000);
        do_ack("rm");
        send_beats(64'h1000, 0, 3, 1'b0);
        redirect_valid = 1'b1;
        redirect_rip   = 64'h2004;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("rm_occ0", 128'(occupancy), 128'(0));
        check_eq("rm_rip", 128'(window_rip), 128'(64'h2004));
        check_eq("rm_wvalid", 128'(window_valid), 128'(0));
        send_beats(64'h1000, 3, 5, 1'b1);
        check_eq("rm_drain_occ", 128'(occupancy), 128'(0));
        wait_req("rm_new", 64'h2000);
        do_ack("rm_new");
        send_beats(64'h2000, 0, 8, 1'b0);
        check_eq("rm_new_occ", 128'(occupancy), 128'(60));
        check_eq("rm_new_window", 128'(window), 128'(exp_window(64'h2004)));

        // redirect and consume together: redirect wins
        consume        = 4'd15;
        redirect_valid = 1'b1;
        redirect_rip   = 64'h6000;
        @(negedge clk);
        consume        = '0;
        redirect_valid = 1'b0;
        check_eq("rc_rip", 128'(window_rip), 128'(64'h6000));
        check_eq("rc_occ", 128'(occupancy), 128'(0));

        // redirect while waiting for reqack
        do_reset(64'h3000);
        wait_req("rw", 64'h3000);
        redirect_valid = 1'b1;
        redirect_rip   = 64'h4010;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("rw_hold_cyc", 128'(bus.reqcyc), 128'(1));
        check_eq("rw_hold_req", 128'(bus.req), 128'(64'h3000));
        check_eq("rw_hold_tag", 128'(bus.reqtag), 128'(RD_TAG));
        do_ack("rw");
        send_beats(64'h3000, 0, 8, 1'b1);
        check_eq("rw_drain_occ", 128'(occupancy), 128'(0));
        wait_req("rw_new", 64'h4000);
        do_ack("rw_new");
        send_beats(64'h4000, 0, 8, 1'b0);
        check_eq("rw_new_occ", 128'(occupancy), 128'(48));
        check_eq("rw_new_rip", 128'(window_rip), 128'(64'h4010));
        check_eq("rw_new_window", 128'(window), 128'(exp_window(64'h4010)));

        // reset in the middle of a line
        wait_req("ra", 64'h4040);
        do_ack("ra");
        send_beats(64'h4040, 0, 2, 1'b0);
        do_reset(64'h5020);
        wait_req("ra_new", 64'h5000);
        do_ack("ra_new");
        send_beats(64'h5000, 0, 8, 1'b0);
        check_eq("ra_occ", 128'(occupancy), 128'(32));
        check_eq("ra_window", 128'(window), 128'(exp_window(64'h5020)));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
